shift_register_universal: RTL and testbench

- Parametrised universal shift register; successor to the fixed 8-bit left-shift register.
- Generalised in width (WIDTH) and in bits moved per shift (STEP).
- Adds five shift/rotate modes, a frame counter with done flag, and reserved-mode error reporting.
- Used as a serializer/deserializer and general-purpose data-path shifter.

---
 rtl/shift_register_universal_pkg.sv | 15 +
 rtl/shift_register_universal_frame_counter.sv | 29 ++
 rtl/shift_register_universal.sv | 95 +++++++++
 tb/tb_shift_register_universal.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/shift_register_universal_pkg.sv
// Shared mode encoding for the universal shift register and its helpers.
package shift_pkg;

    typedef enum logic [2:0] {
        SHL = 3'b000,
        SHR = 3'b001,
        ROL = 3'b010,
        ROR = 3'b011,
        ASR = 3'b100
    } shift_mode_e;

    // Encodings at or above this value are reserved and flagged as errors.
    localparam logic [2:0] MODE_RSVD_MIN = 3'd5;

endpackage

// File: rtl/shift_register_universal_frame_counter.sv
// Saturating frame counter with a sticky done flag, cleared by clr or rst.
module shift_frame_counter #(
    parameter int unsigned MAX   = 8,
    parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (inc) begin
            if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            // done rises together with the increment that reaches MAX.
            if (cnt >= CNT_MAX - 1'b1)
                done <= 1'b1;
        end
    end

endmodule

// File: rtl/shift_register_universal.sv
// Parametrised universal shift register (SHL/SHR/ROL/ROR/ASR) with frame counter.
// Optional registered parity output enabled by `define SHIFT_REG_PARITY_EN.
module shift_register_universal
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1,
    parameter int unsigned CNT_W = $clog2(WIDTH / STEP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [2:0]       mode,
    input  logic [STEP-1:0]  serial_in_lo,
    input  logic [STEP-1:0]  serial_in_hi,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  serial_out_hi,
    output logic [STEP-1:0]  serial_out_lo,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done,
    output logic             err
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int unsigned FRAME = WIDTH / STEP;

    generate
        if (WIDTH < 2 || STEP < 1 || STEP >= WIDTH || (WIDTH % STEP) != 0) begin : g_param_check
            $error("shift_register_universal: illegal WIDTH/STEP combination");
        end
    endgenerate

    logic [WIDTH-1:0] q_next;
    logic             err_next;
    logic             inc;

    always_comb begin
        q_next   = q;
        err_next = 1'b0;
        inc      = 1'b0;
        if (load) begin
            q_next = parallel_in;
        end else if (shift_en) begin
            inc = (mode < MODE_RSVD_MIN);
            case (mode)
                SHL:     q_next = {q[WIDTH-1-STEP:0], serial_in_lo};
                SHR:     q_next = {serial_in_hi, q[WIDTH-1:STEP]};
                ROL:     q_next = {q[WIDTH-1-STEP:0], q[WIDTH-1 -: STEP]};
                ROR:     q_next = {q[STEP-1:0], q[WIDTH-1:STEP]};
                ASR:     q_next = {{STEP{q[WIDTH-1]}}, q[WIDTH-1:STEP]};
                default: err_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            err <= 1'b0;
        end else begin
            q   <= q_next;
            err <= err_next;
        end
    end

`ifdef SHIFT_REG_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            parity <= 1'b0;
        else
            parity <= ^q_next;
    end
`endif

    shift_frame_counter #(
        .MAX   (FRAME),
        .CNT_W (CNT_W)
    ) u_frame_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .inc  (inc),
        .cnt  (shift_cnt),
        .done (done)
    );

    assign serial_out_hi = q[WIDTH-1 -: STEP];
    assign serial_out_lo = q[STEP-1:0];

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench: two instances (STEP=1 and STEP=2) against an arithmetic reference model.
module tb_shift_register_universal;

    logic       clk = 1'b0;
    logic       rst, load, shift_en;
    logic [2:0] mode;
    logic [7:0] parallel_in;
    logic       sin_lo1, sin_hi1;
    logic [1:0] sin_lo2, sin_hi2;

    logic [7:0] q1, q2;
    logic       sohi1, solo1;
    logic [1:0] sohi2, solo2;
    logic [3:0] cnt1;
    logic [2:0] cnt2;
    logic       done1, done2, err1, err2;
`ifdef SHIFT_REG_PARITY_EN
    logic       par1, par2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_q1, m_q2;
    int         m_cnt1, m_cnt2;
    logic       m_done1, m_done2, m_err1, m_err2;

    always #5 clk = ~clk;

    shift_register_universal #(.WIDTH(8), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .shift_en(shift_en), .mode(mode),
        .serial_in_lo(sin_lo1), .serial_in_hi(sin_hi1), .parallel_in(parallel_in),
        .q(q1), .serial_out_hi(sohi1), .serial_out_lo(solo1),
        .shift_cnt(cnt1), .done(done1), .err(err1)
`ifdef SHIFT_REG_PARITY_EN
        , .parity(par1)
`endif
    );

    shift_register_universal #(.WIDTH(8), .STEP(2)) dut2 (
        .clk(clk), .rst(rst), .load(load), .shift_en(shift_en), .mode(mode),
        .serial_in_lo(sin_lo2), .serial_in_hi(sin_hi2), .parallel_in(parallel_in),
        .q(q2), .serial_out_hi(sohi2), .serial_out_lo(solo2),
        .shift_cnt(cnt2), .done(done2), .err(err2)
`ifdef SHIFT_REG_PARITY_EN
        , .parity(par2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference behaviour of an 8-bit register moving s bits per shift.
    task automatic model_step(input int s, input logic [7:0] in_lo, input logic [7:0] in_hi,
                              inout logic [7:0] mq, inout int mc, inout logic md, inout logic me);
        int frame;
        frame = 8 / s;
        if (rst) begin
            mq = 8'h00; mc = 0; md = 1'b0; me = 1'b0;
        end else if (load) begin
            mq = parallel_in; mc = 0; md = 1'b0; me = 1'b0;
        end else if (shift_en) begin
            me = 1'b0;
            case (mode)
                3'd0: mq = (mq << s) | in_lo;
                3'd1: mq = (mq >> s) | (in_hi << (8 - s));
                3'd2: mq = (mq << s) | (mq >> (8 - s));
                3'd3: mq = (mq >> s) | (mq << (8 - s));
                3'd4: mq = 8'($signed(mq) >>> s);
                default: me = 1'b1;
            endcase
            if (!me) begin
                if (mc < frame) mc++;
                if (mc == frame) md = 1'b1;
            end
        end else begin
            me = 1'b0;
        end
    endtask

    task automatic check_all();
        check("q1",    32'(q1),    32'(m_q1));
        check("cnt1",  32'(cnt1),  32'(m_cnt1));
        check("done1", 32'(done1), 32'(m_done1));
        check("err1",  32'(err1),  32'(m_err1));
        check("sohi1", 32'(sohi1), 32'(m_q1[7]));
        check("solo1", 32'(solo1), 32'(m_q1[0]));
        check("q2",    32'(q2),    32'(m_q2));
        check("cnt2",  32'(cnt2),  32'(m_cnt2));
        check("done2", 32'(done2), 32'(m_done2));
        check("err2",  32'(err2),  32'(m_err2));
        check("sohi2", 32'(sohi2), 32'(m_q2[7:6]));
        check("solo2", 32'(solo2), 32'(m_q2[1:0]));
`ifdef SHIFT_REG_PARITY_EN
        check("par1",  32'(par1),  32'(^m_q1));
        check("par2",  32'(par2),  32'(^m_q2));
`endif
    endtask

    // One clock: model consumes the inputs present at the edge, then compare 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step(1, {7'b0, sin_lo1}, {7'b0, sin_hi1}, m_q1, m_cnt1, m_done1, m_err1);
        model_step(2, {6'b0, sin_lo2}, {6'b0, sin_hi2}, m_q2, m_cnt2, m_done2, m_err2);
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic l, input logic se, input logic [2:0] m,
                         input logic [7:0] pin);
        rst = r; load = l; shift_en = se; mode = m; parallel_in = pin;
    endtask

    initial begin
        m_q1 = 8'hxx; m_q2 = 8'hxx; m_cnt1 = 0; m_cnt2 = 0;
        m_done1 = 1'b0; m_done2 = 1'b0; m_err1 = 1'b0; m_err2 = 1'b0;
        sin_lo1 = 1'b0; sin_hi1 = 1'b0; sin_lo2 = 2'b00; sin_hi2 = 2'b00;

        drive(1, 0, 0, 3'd0, 8'h00); cycle();
        check("rst_q1", 32'(q1), 32'h0);
        check("rst_cnt2", 32'(cnt2), 32'h0);

        drive(0, 1, 0, 3'd0, 8'hA5); cycle();
        drive(0, 0, 1, 3'd0, 8'h00); sin_lo1 = 1'b1; sin_lo2 = 2'b11; cycle();
        check("shl_s1", 32'(q1), 32'h4B);
        check("shl_s1_hi", 32'(sohi1), 32'h0);
        check("shl_s1_cnt", 32'(cnt1), 32'h1);
        check("shl_s2", 32'(q2), 32'h97);

        drive(0, 1, 0, 3'd0, 8'h81); cycle();
        drive(0, 0, 1, 3'd4, 8'h00); cycle();
        check("asr_s1", 32'(q1), 32'hC0);
        drive(0, 1, 0, 3'd0, 8'h01); cycle();
        drive(0, 0, 1, 3'd3, 8'h00); cycle();
        check("ror_s1", 32'(q1), 32'h80);
        drive(0, 0, 1, 3'd2, 8'h00); cycle();
        check("rol_s1", 32'(q1), 32'h01);

        drive(0, 1, 0, 3'd0, 8'h00); cycle();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 3'd0, 8'h00); cycle();
        end
        check("frame_done2", 32'(done2), 32'h1);
        check("frame_cnt2", 32'(cnt2), 32'h4);
        cycle();
        check("sat_cnt2", 32'(cnt2), 32'h4);
        check("sat_done2", 32'(done2), 32'h1);
        drive(0, 1, 1, 3'd1, 8'h5A); cycle();
        check("ld_pri_q2", 32'(q2), 32'h5A);
        check("ld_pri_cnt2", 32'(cnt2), 32'h0);
        check("ld_pri_done2", 32'(done2), 32'h0);

        drive(0, 1, 0, 3'd0, 8'h3C); cycle();
        drive(0, 0, 1, 3'b110, 8'h00); cycle();
        check("rsvd_q1", 32'(q1), 32'h3C);
        check("rsvd_err1", 32'(err1), 32'h1);
        check("rsvd_cnt1", 32'(cnt1), 32'h0);
        drive(0, 0, 0, 3'bxxx, 8'h00); cycle();
        check("rsvd_err_clr", 32'(err1), 32'h0);

        drive(0, 0, 1, 3'd1, 8'h00); sin_hi1 = 1'b1; sin_hi2 = 2'b10; cycle(); cycle();
        check("mid_cnt1", 32'(cnt1), 32'h2);
        drive(1, 0, 1, 3'd1, 8'h00); cycle();
        check("mid_rst_q2", 32'(q2), 32'h0);
        check("mid_rst_cnt1", 32'(cnt1), 32'h0);

`ifdef SHIFT_REG_PARITY_EN
        drive(0, 1, 0, 3'd0, 8'h07); cycle();
        check("parity_07", 32'(par1), 32'h1);
`endif

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 8'($urandom));
            sin_lo1 = 1'($urandom); sin_hi1 = 1'($urandom);
            sin_lo2 = 2'($urandom); sin_hi2 = 2'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
